// File: rtl/y_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 subset sequencer
// and its ALU-op decoder.
package y_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LW  = 7'h03;
  localparam logic [6:0] OPC_SW  = 7'h23;
  localparam logic [6:0] OPC_BEQ = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b000;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  function automatic logic opc_legal(input logic [6:0] opc);
    return opc inside {OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BEQ, OPC_JAL};
  endfunction

endpackage

// File: rtl/y_alu_op_dec.sv
// ALU operation decode from opcode/funct3/ins[30]; purely combinational so
// the single-cycle top can reuse it unchanged.
module y_alu_op_dec
  import y_multicycle_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_ins30,
  output logic [2:0] o_op
);

  always_comb begin
    o_op = ALU_ADD;
    if (i_opcode == OPC_BEQ) begin
      o_op = ALU_SUB;
    end else if (i_opcode == OPC_R) begin
      if (i_ins30)                 o_op = ALU_SUB;
      else if (i_funct3 == 3'b110) o_op = ALU_OR;
      else if (i_funct3 == 3'b111) o_op = ALU_AND;
    end
  end

endmodule

// File: rtl/y_multicycle_ctrl.sv
// Multi-cycle sequencer for the yIF/yID/yEX/yDM/yWB datapath: steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives all strobes.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | ir_we, instruction latched into IR
// DECODE | opcode/funct fields captured, illegal opcode halts
// EXEC   | ALU operation; beq retires here
// MEM    | data-memory access held until dmem_ready; sw retires here
// WB     | register write-back and PC update
// HALT   | illegal opcode or instruction limit reached; exits only via reset
module y_multicycle_ctrl
  import y_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_INSTR = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [31:0]      i_ins,
  input  logic             i_zero,
  input  logic             i_dmem_ready,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic [1:0]       o_pc_sel,
  output logic             o_reg_write,
  output logic             o_alu_src,
  output logic [2:0]       o_op,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [1:0]       o_mem2reg,
  output logic [CNT_W-1:0] o_instr_count
);

  localparam logic [CNT_W:0] MAX_L = (CNT_W+1)'(MAX_INSTR);

  state_t           r_state;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic             r_ins30;
  logic [CNT_W-1:0] r_cnt;

  logic   [2:0] w_op_dec;
  logic         w_is_i, w_is_lw, w_is_sw, w_is_beq, w_is_jal;
  logic         w_pc_we, w_last;
  state_t       w_after_retire;
  logic         w_unused;

  assign w_unused = ^{i_ins[31], i_ins[29:15], i_ins[11:7]};

  assign w_is_i   = (r_opcode == OPC_I);
  assign w_is_lw  = (r_opcode == OPC_LW);
  assign w_is_sw  = (r_opcode == OPC_SW);
  assign w_is_beq = (r_opcode == OPC_BEQ);
  assign w_is_jal = (r_opcode == OPC_JAL);

  assign w_last = (MAX_INSTR != 0) && (({1'b0, r_cnt} + (CNT_W+1)'(1)) == MAX_L);
  assign w_after_retire = w_last ? ST_HALT : ST_FETCH;

  y_alu_op_dec u_alu_op_dec (
    .i_opcode (r_opcode),
    .i_funct3 (r_funct3),
    .i_ins30  (r_ins30),
    .o_op     (w_op_dec)
  );

  // ALU controls stay valid through MEM and WB so the unregistered ALU
  // result still feeds the memory address and the write-back value.
  always_comb begin
    o_op        = ALU_ADD;
    o_alu_src   = 1'b0;
    o_pc_sel    = PC_SEL_INC;
    o_reg_write = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem2reg   = WB_ALU;
    w_pc_we     = 1'b0;
    if (r_state inside {ST_EXEC, ST_MEM, ST_WB}) begin
      o_op      = w_op_dec;
      o_alu_src = w_is_i || w_is_lw || w_is_sw;
    end
    case (r_state)
      ST_EXEC: begin
        if (w_is_beq) begin
          w_pc_we  = 1'b1;
          o_pc_sel = i_zero ? PC_SEL_BR : PC_SEL_INC;
        end
      end
      ST_MEM: begin
        o_mem_read  = w_is_lw;
        o_mem_write = w_is_sw;
        w_pc_we     = w_is_sw && i_dmem_ready;
      end
      ST_WB: begin
        o_reg_write = 1'b1;
        w_pc_we     = 1'b1;
        o_mem2reg   = w_is_lw ? WB_MEM : (w_is_jal ? WB_PC4 : WB_ALU);
        o_pc_sel    = w_is_jal ? PC_SEL_JMP : PC_SEL_INC;
      end
      default: ;
    endcase
  end

  assign o_pc_we       = w_pc_we;
  assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign o_halted      = (r_state == ST_HALT);
  assign o_ir_we       = (r_state == ST_FETCH);
  assign o_instr_count = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_opcode <= '0;
      r_funct3 <= '0;
      r_ins30  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_pc_we && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        ST_IDLE:   if (i_start) r_state <= ST_FETCH;
        ST_FETCH:  r_state <= ST_DECODE;
        ST_DECODE: begin
          r_opcode <= i_ins[6:0];
          r_funct3 <= i_ins[14:12];
          r_ins30  <= i_ins[30];
          r_state  <= opc_legal(i_ins[6:0]) ? ST_EXEC : ST_HALT;
        end
        ST_EXEC: begin
          if (w_is_beq)                 r_state <= w_after_retire;
          else if (w_is_lw || w_is_sw)  r_state <= ST_MEM;
          else                          r_state <= ST_WB;
        end
        ST_MEM:    if (i_dmem_ready) r_state <= w_is_lw ? ST_WB : w_after_retire;
        ST_WB:     r_state <= w_after_retire;
        default:   r_state <= r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_y_multicycle_ctrl.sv
// Directed bench for y_multicycle_ctrl: per-instruction strobe timing,
// branch/jump selects, memory wait states, halt and reset behaviour.
module tb_y_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_zero, i_dmem_ready;
  logic [31:0] i_ins;

  logic        o_busy, o_halted, o_ir_we, o_pc_we, o_reg_write, o_alu_src;
  logic        o_mem_read, o_mem_write;
  logic [1:0]  o_pc_sel, o_mem2reg;
  logic [2:0]  o_op;
  logic [15:0] o_instr_count;

  logic        m2_busy, m2_halted;
  logic [15:0] m2_instr_count;
  logic        m2_unused_ir_we, m2_unused_pc_we, m2_unused_reg_write, m2_unused_alu_src;
  logic        m2_unused_mem_read, m2_unused_mem_write;
  logic [1:0]  m2_unused_pc_sel, m2_unused_mem2reg;
  logic [2:0]  m2_unused_op;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  y_multicycle_ctrl #(.CNT_W(16), .MAX_INSTR(0)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_ins(i_ins),
    .i_zero(i_zero), .i_dmem_ready(i_dmem_ready),
    .o_busy(o_busy), .o_halted(o_halted), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we),
    .o_pc_sel(o_pc_sel), .o_reg_write(o_reg_write), .o_alu_src(o_alu_src),
    .o_op(o_op), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem2reg(o_mem2reg), .o_instr_count(o_instr_count)
  );

  y_multicycle_ctrl #(.CNT_W(16), .MAX_INSTR(2)) u_dut_max2 (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_ins(i_ins),
    .i_zero(i_zero), .i_dmem_ready(i_dmem_ready),
    .o_busy(m2_busy), .o_halted(m2_halted), .o_ir_we(m2_unused_ir_we),
    .o_pc_we(m2_unused_pc_we), .o_pc_sel(m2_unused_pc_sel),
    .o_reg_write(m2_unused_reg_write), .o_alu_src(m2_unused_alu_src),
    .o_op(m2_unused_op), .o_mem_read(m2_unused_mem_read),
    .o_mem_write(m2_unused_mem_write), .o_mem2reg(m2_unused_mem2reg),
    .o_instr_count(m2_instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the FETCH cycle (cycle 1); leaves in the next FETCH/HALT cycle.
  task automatic exec_instr(input string tag, input logic [31:0] instr, input logic zero,
                            input int wait_n, input int exp_cyc, input logic [2:0] exp_op,
                            input logic exp_src, input logic [1:0] exp_pcsel,
                            input logic [1:0] exp_m2r, input int exp_regw,
                            input int exp_rd, input int exp_wr);
    int cyc = 1, mem_n = 0, regw_n = 0, rd_n = 0, wr_n = 0, clash = 0;
    logic       irwe_c1 = o_ir_we;
    logic [2:0] op_c3 = 3'bx;
    logic       src_c3 = 1'bx;
    logic [1:0] pcsel_r = 2'bx, m2r_r = 2'bx;
    i_ins  = instr;
    i_zero = zero;
    while (cyc < 30) begin
      if (o_mem_read || o_mem_write) begin
        mem_n++;
        i_dmem_ready = (mem_n > wait_n);
      end
      #1;
      if (cyc == 3) begin
        op_c3  = o_op;
        src_c3 = o_alu_src;
      end
      regw_n += int'(o_reg_write);
      rd_n   += int'(o_mem_read);
      wr_n   += int'(o_mem_write);
      if (o_ir_we && (o_reg_write || o_mem_write || o_pc_we)) clash++;
      if (o_pc_we) begin
        pcsel_r = o_pc_sel;
        m2r_r   = o_mem2reg;
        break;
      end
      tick();
      cyc++;
    end
    tick();
    i_dmem_ready = 1'b1;
    exp_cnt++;
    chk({tag, ".ir_we_c1"}, 32'(irwe_c1), 32'd1);
    chk({tag, ".cycles"},   32'(cyc), 32'(exp_cyc));
    chk({tag, ".op"},       32'(op_c3), 32'(exp_op));
    chk({tag, ".alu_src"},  32'(src_c3), 32'(exp_src));
    chk({tag, ".pc_sel"},   32'(pcsel_r), 32'(exp_pcsel));
    chk({tag, ".mem2reg"},  32'(m2r_r), 32'(exp_m2r));
    chk({tag, ".regw_n"},   32'(regw_n), 32'(exp_regw));
    chk({tag, ".rd_n"},     32'(rd_n), 32'(exp_rd));
    chk({tag, ".wr_n"},     32'(wr_n), 32'(exp_wr));
    chk({tag, ".clash"},    32'(clash), 32'd0);
    chk({tag, ".count"},    32'(o_instr_count), 32'(exp_cnt));
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_zero = 1'b0; i_dmem_ready = 1'b1; i_ins = '0;
    tick(); tick();
    i_reset = 1'b0;
    tick();
    chk("rst.busy",      32'(o_busy), 32'd0);
    chk("rst.halted",    32'(o_halted), 32'd0);
    chk("rst.ir_we",     32'(o_ir_we), 32'd0);
    chk("rst.pc_we",     32'(o_pc_we), 32'd0);
    chk("rst.pc_sel",    32'(o_pc_sel), 32'd0);
    chk("rst.reg_write", 32'(o_reg_write), 32'd0);
    chk("rst.alu_src",   32'(o_alu_src), 32'd0);
    chk("rst.op",        32'(o_op), 32'h2);
    chk("rst.mem_read",  32'(o_mem_read), 32'd0);
    chk("rst.mem_write", 32'(o_mem_write), 32'd0);
    chk("rst.mem2reg",   32'(o_mem2reg), 32'd0);
    chk("rst.count",     32'(o_instr_count), 32'd0);

    pulse_start();
    chk("start.busy", 32'(o_busy), 32'd1);
    //          tag      instr         z  wt cyc op     src  pcsel  m2r   rw rd wr
    exec_instr("add",   32'h002081B3, 0, 0, 4, 3'b010, 0, 2'b00, 2'b00, 1, 0, 0);
    exec_instr("or",    32'h0020E1B3, 0, 0, 4, 3'b001, 0, 2'b00, 2'b00, 1, 0, 0);
    exec_instr("sub",   32'h402081B3, 0, 0, 4, 3'b110, 0, 2'b00, 2'b00, 1, 0, 0);
    exec_instr("and",   32'h0020F1B3, 0, 0, 4, 3'b000, 0, 2'b00, 2'b00, 1, 0, 0);
    exec_instr("addi",  32'h00500093, 0, 0, 4, 3'b010, 1, 2'b00, 2'b00, 1, 0, 0);
    exec_instr("lw_w3", 32'h0000A203, 0, 3, 8, 3'b010, 1, 2'b00, 2'b01, 1, 4, 0);
    exec_instr("sw",    32'h0040A223, 0, 0, 4, 3'b010, 1, 2'b00, 2'b00, 0, 0, 1);
    exec_instr("beq_t", 32'h00208463, 1, 0, 3, 3'b110, 0, 2'b01, 2'b00, 0, 0, 0);
    exec_instr("beq_n", 32'h00208463, 0, 0, 3, 3'b110, 0, 2'b00, 2'b00, 0, 0, 0);
    exec_instr("jal",   32'h008000EF, 0, 0, 4, 3'b010, 0, 2'b10, 2'b10, 1, 0, 0);

    // reset in the middle of a stalled sw
    i_ins = 32'h0040A223;
    i_dmem_ready = 1'b0;
    tick(); tick(); tick();
    chk("swrst.mem_write_pre", 32'(o_mem_write), 32'd1);
    i_reset = 1'b1;
    tick();
    chk("swrst.mem_write", 32'(o_mem_write), 32'd0);
    chk("swrst.busy",      32'(o_busy), 32'd0);
    chk("swrst.count",     32'(o_instr_count), 32'd0);
    i_reset = 1'b0;
    i_dmem_ready = 1'b1;
    exp_cnt = 0;
    tick();
    chk("swrst.idle_busy", 32'(o_busy), 32'd0);
    chk("swrst.idle_irwe", 32'(o_ir_we), 32'd0);

    // illegal opcode halts without retiring
    pulse_start();
    i_ins = 32'h0000007F;
    tick();
    chk("ill.decode_pc_we", 32'(o_pc_we), 32'd0);
    tick();
    chk("ill.halted", 32'(o_halted), 32'd1);
    chk("ill.busy",   32'(o_busy), 32'd0);
    chk("ill.pc_we",  32'(o_pc_we), 32'd0);
    chk("ill.count",  32'(o_instr_count), 32'd0);
    pulse_start();
    tick();
    chk("ill.start_ignored", 32'(o_halted), 32'd1);
    chk("ill.no_fetch",      32'(o_ir_we), 32'd0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("ill.reset_clears", 32'(o_halted), 32'd0);

    // instruction limit on the MAX_INSTR=2 instance
    pulse_start();
    exec_instr("max_a1", 32'h00500093, 0, 0, 4, 3'b010, 1, 2'b00, 2'b00, 1, 0, 0);
    chk("max.halted_1", 32'(m2_halted), 32'd0);
    chk("max.count_1",  32'(m2_instr_count), 32'd1);
    exec_instr("max_a2", 32'h00100113, 0, 0, 4, 3'b010, 1, 2'b00, 2'b00, 1, 0, 0);
    chk("max.halted_2", 32'(m2_halted), 32'd1);
    chk("max.busy_2",   32'(m2_busy), 32'd0);
    chk("max.count_2",  32'(m2_instr_count), 32'd2);
    chk("max.unlimited_busy", 32'(o_busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
